dmem_resp: RTL and testbench
============================

// Module: dmem_resp
// PURPOSE
//  Data-memory responder for the ECNURVCORE datapath: services load_en/store_en requests issued by the
//  instruction decoder. Holds a word-organised RAM, performs SB/SH/SW byte-lane writes and LB/LH/LW/LBU/LHU
//  extraction with sign/zero extension. Multi-cycle: raises stall so the core freezes PC until done.
// PARAMETERS
//  MEM_DEPTH  1024  RAM depth in 32-bit words (power of 2); AW = $clog2(MEM_DEPTH)
//  WAIT_CYC   1     extra access wait states (0..15) between accept and response
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   reset: synchronous, active-low
//  load_en   in   1   load request (from decoder)
//  store_en  in   1   store request (from decoder)
//  funct3    in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr      in   32  byte address (ALU result)
//  wdata     in   32  store data (rs2); byte/half taken from LSBs
//  stall     out  1   hold PC/regfile write while access pending (combinational)
//  done      out  1   1-cycle pulse: access complete, rdata valid
//  rdata     out  32  extended load data, valid with done
//  mem_err   out  1   1-cycle pulse with done: misaligned or illegal funct3
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, wcnt=0, done=0, rdata=0, mem_err=0. RAM not cleared.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: req=load_en|store_en. On req latch addr,wdata,funct3,is_load; go BUSY (WAIT_CYC>0, wcnt=WAIT_CYC-1)
//          or RESP directly (WAIT_CYC=0).
//    BUSY: wcnt decrements; at wcnt==0 go RESP.
//    RESP: done=1 one cycle; requests ignored this cycle (same instruction retiring); -> IDLE.
//  - stall = (IDLE & req) | BUSY. stall=0 in RESP. Latency: accept edge to done = WAIT_CYC+1 cycles.
//  - load_en & store_en both 1: treated as load; store suppressed.
//  - RAM index = latched addr[AW+1:2]; upper bits ignored (address wraps modulo 4*MEM_DEPTH).
//  - Store commit: on the edge entering RESP; byte enables: SB lane addr[1:0], SH lanes {addr[1],x},
//    SW all four. Unwritten lanes unchanged.
//  - Load: word read on the edge entering RESP; rdata registered then. LB/LH sign-extend, LBU/LHU zero-extend.
//    Store: rdata=0 at done.
//  - Error cases (macro enabled): H with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111},
//    or store with funct3[2]=1 -> no RAM write, rdata=0, mem_err=1 with done. Timing unchanged.
//  - Reset mid-access (BUSY or IDLE accept): access aborted, no RAM write, no done pulse.
//  - Back-to-back: next request accepted earliest in the IDLE cycle after RESP.
// CONFIGURATION
//  DMEM_ERR_CHECK_EN defined: error detection as above; mem_err driven.
//  Not defined: mem_err tied 0; low address bits forced aligned (H: addr[0]=0, W: addr[1:0]=0);
//    illegal funct3 decoded as W; stores with funct3[2]=1 decoded by funct3[1:0].
// TESTING
//  1 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> done after WAIT_CYC+1, rdata=0xDEADBEEF, mem_err=0.
//  2 SB 0x13 wdata=0x80, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  3 SH 0x22 wdata=0x1234F00D, then LH 0x22 -> 0xFFFFF00D; LHU -> 0x0000F00D; bytes 0x20/0x21 unchanged.
//  4 LW 0x11 (macro on) -> done+mem_err=1, rdata=0, RAM unchanged; macro off -> rdata=word at 0x10.
//  5 Store to 0x40 with rst_n=0 during BUSY (WAIT_CYC=3) -> no done; later LW 0x40 returns prior contents.
//  6 WAIT_CYC=0: stall high exactly 1 cycle per access; load_en&store_en=1 -> load result, RAM unchanged.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the ECNURVCORE datapath.
// Word-organised RAM with SB/SH/SW byte-lane writes and LB/LH/LW/LBU/LHU
// extraction. Each access walks IDLE -> (BUSY) -> RESP; stall freezes the
// core until the single-cycle done pulse.
// Optional feature macro: DMEM_ERR_CHECK_EN enables misalignment / illegal
// funct3 detection on mem_err. Without it, low address bits are forced
// aligned and illegal encodings fall back to word accesses.
module dmem_resp #(
    parameter int MEM_DEPTH = 1024,
    parameter int WAIT_CYC  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        mem_err
);
    localparam int         AW        = $clog2(MEM_DEPTH);
    localparam logic [3:0] WCNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wcnt;
    logic          req;
    logic          accept;
    logic          enter_resp;
    logic          err_q;

    // Request captured at accept; used while waiting in BUSY.
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [2:0]    lat_f3;
    logic          lat_load;

    // Request seen by the access logic (live inputs in IDLE, latched later).
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic [2:0]    acc_f3;
    logic          acc_load;

    logic          is_b;
    logic          is_h;
    logic [1:0]    lo;
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic          we;
    logic [AW-1:0] idx;

    logic [31:0]   mem [MEM_DEPTH];

    // Upper address bits beyond the RAM span are intentionally ignored.
    logic          unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    // Select the lane and extend the loaded byte/half according to funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  low,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (low)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = low[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req  = load_en | store_en;
    assign done = (state == RESP);
    assign mem_err = done & err_q;

    // Next-state, accept and stall decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = (WAIT_CYC == 0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (wcnt == 4'd0) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // Pick live inputs when the access completes in the accept cycle itself.
    always_comb begin
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        acc_f3    = lat_f3;
        acc_load  = lat_load;
        if (state == IDLE) begin
            acc_addr  = addr[AW+1:0];
            acc_wdata = wdata;
            acc_f3    = funct3;
            acc_load  = load_en;
        end
    end

    // Size/alignment/error decode, byte enables and replicated store data.
    always_comb begin
        is_b    = (acc_f3[1:0] == 2'b00);
        is_h    = (acc_f3[1:0] == 2'b01);
        lo      = acc_addr[1:0];
        acc_err = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        acc_err = (acc_f3 == 3'b011) || (acc_f3 == 3'b110) || (acc_f3 == 3'b111)
                || (!acc_load && acc_f3[2])
                || (is_h && lo[0])
                || (!is_b && !is_h && (lo != 2'b00));
`else
        if (is_h)       lo[0] = 1'b0;
        else if (!is_b) lo    = 2'b00;
`endif
        if (is_b)      be = 4'b0001 << lo;
        else if (is_h) be = lo[1] ? 4'b1100 : 4'b0011;
        else           be = 4'b1111;
        if (is_b)      wr_word = {4{acc_wdata[7:0]}};
        else if (is_h) wr_word = {2{acc_wdata[15:0]}};
        else           wr_word = acc_wdata;
        idx = acc_addr[AW+1:2];
        we  = enter_resp && rst_n && !acc_load && !acc_err;
    end

    // Control state, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= 4'd0;
            rdata <= 32'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)                             wcnt <= WCNT_INIT;
            else if (state == BUSY && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
            if (enter_resp) begin
                err_q <= acc_err;
                rdata <= (acc_err || !acc_load) ? 32'd0 : load_extend(mem[idx], lo, acc_f3);
            end
        end
    end

    // Capture the request on accept (data path, no reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= addr[AW+1:0];
            lat_wdata <= wdata;
            lat_f3    <= funct3;
            lat_load  <= load_en;
        end
    end

    // Byte-lane RAM write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[idx][7:0]   <= wr_word[7:0];
            if (be[1]) mem[idx][15:8]  <= wr_word[15:8];
            if (be[2]) mem[idx][23:16] <= wr_word[23:16];
            if (be[3]) mem[idx][31:24] <= wr_word[31:24];
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: instance 0 with WAIT_CYC=3, instance 1 with WAIT_CYC=0.
// A byte-level memory model plus request timestamps predicts done/stall/
// rdata/mem_err each cycle; directed accesses add literal expectations.
module tb_dmem_resp;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        le [2];
    logic        se [2];
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic        st [2];
    logic        dn [2];
    logic        me [2];
    logic [31:0] rd [2];

    int n_chk = 0;
    int n_fail = 0;

    // Model state
    logic [7:0]  mm [2][4096];
    bit          pend [2];
    bit          resp [2];
    int          due [2];
    int          mcyc [2];
    logic        q_ld [2];
    logic [2:0]  q_f3 [2];
    logic [31:0] q_a [2];
    logic [31:0] q_wd [2];
    logic [31:0] exp_rd [2];
    bit          exp_err [2];

    always #5 clk = ~clk;

    dmem_resp #(.MEM_DEPTH(1024), .WAIT_CYC(3)) u_dut_w3 (
        .clk(clk), .rst_n(rst_n[0]), .load_en(le[0]), .store_en(se[0]),
        .funct3(f3[0]), .addr(ad[0]), .wdata(wd[0]),
        .stall(st[0]), .done(dn[0]), .rdata(rd[0]), .mem_err(me[0])
    );

    dmem_resp #(.MEM_DEPTH(1024), .WAIT_CYC(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n[1]), .load_en(le[1]), .store_en(se[1]),
        .funct3(f3[1]), .addr(ad[1]), .wdata(wd[1]),
        .stall(st[1]), .done(dn[1]), .rdata(rd[1]), .mem_err(me[1])
    );

    function automatic int wait_of(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    // Apply one completed access to the byte memory model.
    task automatic model_access(input int i);
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] v;
        int          sz;
        int          base;
        bit          err;
        f   = q_f3[i];
        a   = q_a[i];
        err = 1'b0;
        case (f[1:0])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            default: sz = 4;
        endcase
`ifdef DMEM_ERR_CHECK_EN
        if (f == 3'b011 || f == 3'b110 || f == 3'b111) err = 1'b1;
        if (!q_ld[i] && f[2]) err = 1'b1;
        if (sz == 2 && a[0]) err = 1'b1;
        if (sz == 4 && a[1:0] != 2'b00) err = 1'b1;
`else
        if (sz == 2) a[0] = 1'b0;
        if (sz == 4) a[1:0] = 2'b00;
`endif
        base = int'(a % 32'd4096);
        exp_err[i] = err;
        if (err) begin
            exp_rd[i] = 32'd0;
        end else if (q_ld[i]) begin
            v = 32'd0;
            for (int k = 0; k < sz; k++) v = v | (32'(mm[i][base + k]) << (8 * k));
            if (sz == 1 && !f[2] && v[7])  v = v | 32'hFFFF_FF00;
            if (sz == 2 && !f[2] && v[15]) v = v | 32'hFFFF_0000;
            exp_rd[i] = v;
        end else begin
            for (int k = 0; k < sz; k++) mm[i][base + k] = 8'(q_wd[i] >> (8 * k));
            exp_rd[i] = 32'd0;
        end
    endtask

    // Advance the model one clock edge using the inputs seen at that edge.
    task automatic model_step(input int i);
        mcyc[i]++;
        if (!rst_n[i]) begin
            pend[i] = 1'b0;
            resp[i] = 1'b0;
        end else if (resp[i]) begin
            resp[i] = 1'b0;
        end else begin
            if (!pend[i] && (le[i] || se[i])) begin
                pend[i] = 1'b1;
                due[i]  = mcyc[i] + wait_of(i);
                q_ld[i] = le[i];
                q_f3[i] = f3[i];
                q_a[i]  = ad[i];
                q_wd[i] = wd[i];
            end
            if (pend[i] && mcyc[i] == due[i]) begin
                model_access(i);
                pend[i] = 1'b0;
                resp[i] = 1'b1;
            end
        end
    endtask

    task automatic check(input int i);
        logic exp_st;
        exp_st = !resp[i] && (pend[i] || le[i] || se[i]);
        n_chk++;
        if (dn[i] !== resp[i]) begin
            n_fail++;
            $display("FAIL done inst%0d cyc%0d: got %b expected %b", i, mcyc[i], dn[i], resp[i]);
        end
        n_chk++;
        if (st[i] !== exp_st) begin
            n_fail++;
            $display("FAIL stall inst%0d cyc%0d: got %b expected %b", i, mcyc[i], st[i], exp_st);
        end
        n_chk++;
        if (me[i] !== (resp[i] && exp_err[i])) begin
            n_fail++;
            $display("FAIL mem_err inst%0d cyc%0d: got %b expected %b", i, mcyc[i], me[i], resp[i] && exp_err[i]);
        end
        if (resp[i]) begin
            n_chk++;
            if (rd[i] !== exp_rd[i]) begin
                n_fail++;
                $display("FAIL rdata inst%0d cyc%0d: got %08h expected %08h", i, mcyc[i], rd[i], exp_rd[i]);
            end
        end
    endtask

    // Model update at the edge, comparison shortly after it.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #2;
        check(0);
        check(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Issue one request, hold it until done, return result, latency and stall count.
    task automatic access(input int i, input logic ld, input logic sto, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] w,
                          output logic [31:0] r, output logic e, output int lat, output int stc);
        bit got;
        @(negedge clk);
        le[i] = ld; se[i] = sto; f3[i] = f; ad[i] = a; wd[i] = w;
        #1;
        stc = st[i] ? 1 : 0;
        lat = 0;
        got = 1'b0;
        r   = 32'd0;
        e   = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (dn[i]) begin
                got = 1'b1;
                r   = rd[i];
                e   = me[i];
            end else if (st[i]) begin
                stc++;
            end
        end
        le[i] = 1'b0; se[i] = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout inst%0d: got no done expected done within 40 cycles", i);
        end
    endtask

    task automatic do_store(input int i, input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] r;
        logic        e;
        int          lat;
        int          stc;
        access(i, 1'b0, 1'b1, f, a, w, r, e, lat, stc);
        chk("store_rdata", r, 32'd0);
    endtask

    task automatic do_load(input int i, input string nm, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] exp, input logic exp_e);
        logic [31:0] r;
        logic        e;
        int          lat;
        int          stc;
        access(i, 1'b1, 1'b0, f, a, 32'd0, r, e, lat, stc);
        chk(nm, r, exp);
        chk({nm, "_err"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        int          stc;
        int          ndone;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; le[i] = 1'b0; se[i] = 1'b0;
            f3[i] = 3'd0; ad[i] = 32'd0; wd[i] = 32'd0;
            pend[i] = 1'b0; resp[i] = 1'b0; due[i] = 0; mcyc[i] = 0;
            exp_rd[i] = 32'd0; exp_err[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_rdata", rd[i], 32'd0);
            chk("reset_done", {31'd0, dn[i]}, 32'd0);
            chk("reset_err", {31'd0, me[i]}, 32'd0);
            chk("reset_stall", {31'd0, st[i]}, 32'd0);
        end

        // SW then LW, latency WAIT_CYC+1 = 4
        access(0, 1'b0, 1'b1, F_W, 32'h10, 32'hDEAD_BEEF, r, e, lat, stc);
        chk("sw_latency", 32'(lat), 32'd4);
        chk("sw_stall_cycles", 32'(stc), 32'd4);
        chk("sw_err", {31'd0, e}, 32'd0);
        do_load(0, "lw_10", F_W, 32'h10, 32'hDEAD_BEEF, 1'b0);

        // SB and byte/half loads
        do_store(0, F_B, 32'h13, 32'h0000_0080);
        do_load(0, "lb_13", F_B, 32'h13, 32'hFFFF_FF80, 1'b0);
        do_load(0, "lbu_13", F_BU, 32'h13, 32'h0000_0080, 1'b0);
        do_load(0, "lw_10_after_sb", F_W, 32'h10, 32'h80AD_BEEF, 1'b0);
        do_load(0, "lh_10", F_H, 32'h10, 32'hFFFF_BEEF, 1'b0);
        do_load(0, "lb_11", F_B, 32'h11, 32'hFFFF_FFBE, 1'b0);

        // SH upper half, lower bytes untouched
        do_store(0, F_W, 32'h20, 32'hA5A5_5A5A);
        do_store(0, F_H, 32'h22, 32'h1234_F00D);
        do_load(0, "lh_22", F_H, 32'h22, 32'hFFFF_F00D, 1'b0);
        do_load(0, "lhu_22", F_HU, 32'h22, 32'h0000_F00D, 1'b0);
        do_load(0, "lw_20", F_W, 32'h20, 32'hF00D_5A5A, 1'b0);
        do_load(0, "lbu_21", F_BU, 32'h21, 32'h0000_005A, 1'b0);

        // Misaligned / illegal accesses
`ifdef DMEM_ERR_CHECK_EN
        do_load(0, "lw_11_mis", F_W, 32'h11, 32'h0, 1'b1);
        do_load(0, "lw_10_illegal_f3", 3'b011, 32'h10, 32'h0, 1'b1);
        do_store(0, F_H, 32'h21, 32'h0);
        do_load(0, "lw_20_after_bad_sh", F_W, 32'h20, 32'hF00D_5A5A, 1'b0);
`else
        do_load(0, "lw_11_mis", F_W, 32'h11, 32'h80AD_BEEF, 1'b0);
        do_load(0, "lw_10_illegal_f3", 3'b011, 32'h10, 32'h80AD_BEEF, 1'b0);
        do_store(0, F_H, 32'h21, 32'h0);
        do_load(0, "lw_20_after_sh21", F_W, 32'h20, 32'hF00D_0000, 1'b0);
`endif
        do_load(0, "lw_10_unchanged", F_W, 32'h10, 32'h80AD_BEEF, 1'b0);

        // Reset during BUSY aborts the store
        do_store(0, F_W, 32'h40, 32'h1122_3344);
        @(negedge clk);
        se[0] = 1'b1; f3[0] = F_W; ad[0] = 32'h40; wd[0] = 32'h5566_7788;
        @(negedge clk);
        chk("abort_busy_stall", {31'd0, st[0]}, 32'd1);
        se[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn[0]) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        do_load(0, "lw_40_prior", F_W, 32'h40, 32'h1122_3344, 1'b0);

        // Address wrap modulo 4*MEM_DEPTH
        do_store(0, F_W, 32'h0000_1030, 32'h0BAD_CAFE);
        do_load(0, "lw_30_wrap", F_W, 32'h30, 32'h0BAD_CAFE, 1'b0);

        // WAIT_CYC = 0 instance
        access(1, 1'b0, 1'b1, F_W, 32'h10, 32'hCAFE_F00D, r, e, lat, stc);
        chk("w0_latency", 32'(lat), 32'd1);
        chk("w0_stall_cycles", 32'(stc), 32'd1);
        access(1, 1'b1, 1'b1, F_W, 32'h10, 32'h0, r, e, lat, stc);
        chk("w0_both_is_load", r, 32'hCAFE_F00D);
        chk("w0_both_stall", 32'(stc), 32'd1);
        do_load(1, "w0_lw_unchanged", F_W, 32'h10, 32'hCAFE_F00D, 1'b0);
        do_load(1, "w0_lbu_10", F_BU, 32'h10, 32'h0000_000D, 1'b0);
        do_load(1, "w0_lh_12", F_H, 32'h12, 32'hFFFF_CAFE, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
